// File: rtl/sipo_ctrl_pkg.sv
// Shared types for the serial receive controller.
// Holds the FSM state encoding and the default word width.
package sipo_ctrl_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAR,
    STOP
  } state_e;

endpackage

// File: rtl/sipo_shreg.sv
// LSB-first shift register: new bits enter at the MSB.
// Ports: clk, rst (async high), clr_i (sync clear), shift_i, d_i, q_o.
module sipo_shreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             shift_i,
  input  logic             d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else if (clr_i) begin
      sr_q <= '0;
    end else if (shift_i) begin
      sr_q <= {d_i, sr_q[WIDTH-1:1]};
    end
  end

  assign q_o = sr_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Serial frame receiver: start, WIDTH data bits, parity, stop.
// Ports: clk, rst, d/en serial side, q/valid/ready word side,
// busy, parity_err, frame_err, overrun, clr_ovr status.
module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             par_q, par_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  logic             sr_clr;
  logic             sr_shift;
  logic [WIDTH-1:0] sr;
  logic             perr;

  sipo_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (sr_clr),
    .shift_i(sr_shift),
    .d_i    (d),
    .q_o    (sr)
  );

  assign perr = PARITY_EN &&
                ((^sr ^ par_q) != PARITY_ODD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      q_q     <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    q_d      = q_q;
    valid_d  = valid_q;
    perr_d   = perr_q;
    ferr_d   = 1'b0;
    ovr_d    = ovr_q;
    sr_clr   = 1'b0;
    sr_shift = 1'b0;

    // Handshake and clear act every cycle; a completion
    // below overrides both (load keeps valid, set wins).
    if (valid_q && ready) valid_d = 1'b0;
    if (clr_ovr) ovr_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en && !d) begin
          state_d = DATA;
          cnt_d   = '0;
          sr_clr  = 1'b1;
        end
      end
      DATA: begin
        if (en) begin
          sr_shift = 1'b1;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = PARITY_EN ? PAR : STOP;
          end
        end
      end
      PAR: begin
        if (en) begin
          par_d   = d;
          state_d = STOP;
        end
      end
      STOP: begin
        if (en) begin
          state_d = IDLE;
          if (d) begin
            if (!valid_q || ready) begin
              q_d     = sr;
              perr_d  = perr;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign q          = q_q;
  assign valid      = valid_q;
  assign busy       = (state_q != IDLE);
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
Receive-side controller that sequences a serial-in/parallel-out shift register.
- Detects a start bit, counts WIDTH data bits into the shift register, then checks an optional parity bit and a stop bit.
- Presents each completed word on a parallel output register with a valid/ready handshake.
- Sits between a serial line (sampled on a bit strobe) and any parallel consumer in the design.

Parameters:
WIDTH, 4, data bits per frame (2..16)
PARITY_EN, 1, 1 = frame carries a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected

Ports:
clk  in  1  single clock, rising-edge
rst  in  1  asynchronous, active-high reset
d  in  1  serial data in; sampled only when en=1
en  in  1  bit strobe; one cycle per serial bit period
q  out  WIDTH  received word, held while valid=1
valid  out  1  word available in q
ready  in  1  consumer accepts q when valid&&ready
busy  out  1  1 in any state other than IDLE
parity_err  out  1  parity status of the word in q, qualified by valid
frame_err  out  1  one-cycle pulse: stop bit sampled as 0
overrun  out  1  sticky: a word was completed while q was still unaccepted
clr_ovr  in  1  synchronous clear of overrun

Behaviour:
- Reset (async, rst=1): state=IDLE; bit count=0; shift reg=0.
  - Outputs under reset: q=0, valid=0, busy=0, parity_err=0, frame_err=0, overrun=0.
- All state changes occur on rising clk when en=1, except the handshake and clr_ovr, which act every cycle.
- FSM states: IDLE, DATA, PAR, STOP.
  - IDLE: on en&&d==0 (start bit), go to DATA with count=0. d==1 or en=0 → stay in IDLE.
  - DATA: on en, shift LSB-first (sr <= {d, sr[WIDTH-1:1]}) and increment count.
    - After the WIDTH-th bit: go to PAR if PARITY_EN, else STOP.
  - PAR: on en, capture the parity bit p, then go to STOP.
    - perr = (^data ^ p) != PARITY_ODD.
  - STOP: on en, always return to IDLE next cycle.
    - d==1 → word complete; apply the load rules below.
    - d==0 → frame_err=1 for exactly that cycle; word discarded; valid, q and overrun unaffected.
- Load rules on word complete:
  - valid==0, or (valid&&ready) in the same cycle: q<=sr, parity_err<=perr (0 if !PARITY_EN), valid<=1.
  - valid==1 && ready==0: word dropped; q and parity_err unchanged; overrun<=1.
- Handshake:
  - valid&&ready with no completion in the same cycle → valid<=0 next cycle.
  - q is held stable while valid=1.
- clr_ovr=1 clears overrun next cycle.
  - clr_ovr coinciding with a new overrun event: set wins (overrun=1).
- en=0 freezes the FSM and shift register. No timeout.
- Latency: valid rises on the clock edge that samples a good stop bit; q is valid in the same cycle valid=1.
- Reset mid-frame: partial word discarded immediately; no valid and no frame_err produced.
- busy=1 in DATA/PAR/STOP.
- Bit counter width: $clog2(WIDTH+1). Count wraps only via return to IDLE.

Decomposition:
- Package sipo_ctrl_pkg: state enum (IDLE, DATA, PAR, STOP) and the default WIDTH constant.
- One sub-module, sipo_shreg: WIDTH-bit LSB-first shift register with shift-enable and synchronous clear.
- Controller FSM, counter, parity, and output register remain in the top module.

Test Plan:
- Good frame: WIDTH=4, even parity, en every cycle; d = 0, 1,0,1,1, parity 1, stop 1 → q=4'b1101, valid=1, parity_err=0, frame_err=0.
- Bad parity: same frame with parity bit 0 → q=4'b1101, valid=1, parity_err=1.
- Framing error: stop bit 0 → frame_err pulses for 1 cycle, valid stays 0, state returns to IDLE (busy=0 next cycle).
- Backpressure: ready=0; send 4'h3, then 4'hA → q stays 4'h3, overrun=1. Then ready=1 for 1 cycle → valid=0. Then clr_ovr=1 → overrun=0.
- Accept on completion: ready=1 exactly on the stop-bit edge of a second word while the first is valid → q updates to the second word, valid stays 1, overrun=0.
- Strobe and reset: en=1 every 3rd cycle → result identical to the good-frame case. Separately, assert rst after 2 data bits → all outputs 0, no valid; the next full frame is received correctly.
